disp_update_ctrl: RTL and testbench

Scheduler and formatter that sits in front of the seven-segment display driver. It shares the display between two measurement sources (src0, src1) with round-robin arbitration on a fixed refresh tick. It converts the granted binary value (units of 10 mV) to three BCD digits, X.YZ volts, with a sequential double-dabble. It holds the result stable on integer_data/float1_data/float2_data until the next commit.

---
 rtl/disp_pkg.sv | 45 ++++
 rtl/disp_update_ctrl_if.sv | 37 +++
 rtl/bin2bcd_seq.sv | 59 +++++
 rtl/disp_update_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_disp_update_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the display update controller:
//   - FSM state encoding (legacy-compatible 2-bit constants)
//   - BCD accumulator width and saturation value
//   - default refresh period
//   - bcd_add3: the "add 3 to every digit >= 5" step of double-dabble
// -----------------------------------------------------------------------------
package disp_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARB    = 2'd1;
    localparam logic [1:0] ST_CONV   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Three BCD digits: X.YZ volts
    localparam int BCD_W   = 12;
    // Largest displayable value (9.99 V in 10 mV units)
    localparam int SAT_VAL = 999;

    // 0.5 s at 12 MHz
    localparam int DEF_REFRESH_CYCLES = 6000000;

    // Packed view of the three output digits
    typedef struct packed {
        logic [3:0] d_int;
        logic [3:0] d_f1;
        logic [3:0] d_f2;
    } bcd3_t;

    // Double-dabble correction: every digit that is 5 or more gets +3 so that
    // the following left shift carries correctly into the next decade.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/disp_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// disp_update_ctrl_if
// Request/acknowledge bundle between the two measurement sources and the
// display update controller.
//
// Handshake: srcN_req is a level. A source raises it with srcN_val and keeps
// both stable until it sees srcN_ack. srcN_ack is a one-cycle pulse meaning
// "srcN_val has been captured"; the source may then drop req or change val.
// Keeping req high after ack is a new request. Dropping req before ack
// withdraws the request without any side effect.
//
// Signals:
//   src0_req / src1_req  source has a value (master -> slave)
//   src0_val / src1_val  value, unsigned, LSB = 10 mV (master -> slave)
//   src0_ack / src1_ack  capture pulse (slave -> master)
// Modports: master = sources, slave = controller.
// -----------------------------------------------------------------------------
interface disp_update_ctrl_if #(
    parameter int VAL_W = 10
);
    logic             src0_req;
    logic [VAL_W-1:0] src0_val;
    logic             src0_ack;
    logic             src1_req;
    logic [VAL_W-1:0] src1_val;
    logic             src1_ack;

    modport master (
        output src0_req, src0_val, src1_req, src1_val,
        input  src0_ack, src1_ack
    );

    modport slave (
        input  src0_req, src0_val, src1_req, src1_val,
        output src0_ack, src1_ack
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble: converts a VAL_W-bit binary value into a 12-bit
// BCD accumulator, one bit per clock, VAL_W clocks after start.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load bin and begin conversion (ignored bits beyond the
//               accumulator are dropped; callers saturate large values)
//   bin         value to convert, sampled when start=1
//   busy        conversion in progress
//   done        high during the final shift step; bcd holds the finished
//               result from the next cycle until the next start
//   bcd         BCD accumulator {hundreds, tens, units}
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int VAL_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] adj;

    assign adj  = bcd_add3(bcd);
    assign done = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            shreg <= '0;
            cnt   <= '0;
            bcd   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            shreg <= bin;
            cnt   <= CNT_W'(VAL_W);
            bcd   <= '0;
        end else if (busy) begin
            // correct, then shift the next binary MSB into the BCD LSB
            bcd   <= {adj[BCD_W-2:0], shreg[VAL_W-1]};
            shreg <= shreg << 1;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/disp_update_ctrl.sv
// -----------------------------------------------------------------------------
// disp_update_ctrl
// Shares the seven-segment display between two measurement sources. On every
// refresh tick (unless hold) one source is granted round-robin, its value is
// converted to X.YZ volts in BCD and latched onto the digit outputs, which stay
// stable until the next commit.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   src            request/ack bundle for both sources (slave side)
//   hold           freeze: refresh ticks are dropped while high
//   integer_data   BCD volts digit
//   float1_data    BCD tenths digit
//   float2_data    BCD hundredths digit
//   src_id         source of the displayed value
//   overrange      displayed value was saturated to 9.99
//   upd_pulse      one-cycle pulse in the first cycle the new outputs show
//   dbg_state      current FSM state (ST_* encoding from disp_pkg)
//
// Timing, tick in cycle T: ARB T+1, ack T+2, CONV T+2..T+1+VAL_W,
// COMMIT T+2+VAL_W, outputs/upd_pulse from T+3+VAL_W.
// -----------------------------------------------------------------------------
module disp_update_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int VAL_W          = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    disp_update_ctrl_if.slave   src,
    input  logic                hold,
    output logic [3:0]          integer_data,
    output logic [3:0]          float1_data,
    output logic [3:0]          float2_data,
    output logic                src_id,
    output logic                overrange,
    output logic                upd_pulse,
    output logic [1:0]          dbg_state
);
    localparam int TMR_W = $clog2(REFRESH_CYCLES);

    // ---------------------------------------------------------------- timer
    logic [TMR_W-1:0] timer;
    logic             tick;

    assign tick = (timer == TMR_W'(REFRESH_CYCLES - 1));

    // Free-running; deliberately independent of the FSM and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // ------------------------------------------------------------- arbiter
    logic             rr_ptr;     // id of the last granted source
    logic             gnt_vld;
    logic             gnt_id;
    logic [VAL_W-1:0] gnt_val;

    always_comb begin
        gnt_vld = src.src0_req | src.src1_req;
        // with both requesting, the source not granted last time wins
        if (src.src0_req && src.src1_req) begin
            gnt_id = ~rr_ptr;
        end else begin
            gnt_id = src.src1_req;
        end
        gnt_val = gnt_id ? src.src1_val : src.src0_val;
    end

    // ----------------------------------------------------------------- FSM
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       cnv_start;
    logic       cnv_busy;
    logic       cnv_done;
    logic [BCD_W-1:0] cnv_bcd;

    assign cnv_start = (state == ST_ARB) && gnt_vld;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // a tick under hold is dropped, not remembered
                if (tick && !hold) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                state_nxt = gnt_vld ? ST_CONV : ST_IDLE;
            end
            ST_CONV: begin
                if (cnv_done) begin
                    state_nxt = ST_COMMIT;
                end else if (!cnv_busy) begin
                    // converter lost its job; never expected, but do not hang
                    state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------- grant capture + ack
    logic [VAL_W-1:0] cap_val;
    logic             cap_id;
    logic             ack0_q;
    logic             ack1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_val <= '0;
            cap_id  <= 1'b0;
            rr_ptr  <= 1'b1;       // src0 wins the first contest
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            // registered ack lands in the first CONV cycle
            ack0_q <= cnv_start && !gnt_id;
            ack1_q <= cnv_start &&  gnt_id;
            if (cnv_start) begin
                cap_val <= gnt_val;
                cap_id  <= gnt_id;
                rr_ptr  <= gnt_id;
            end
        end
    end

    assign src.src0_ack = ack0_q;
    assign src.src1_ack = ack1_q;

    // ----------------------------------------------------------- converter
    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cnv_start),
        .bin   (gnt_val),
        .busy  (cnv_busy),
        .done  (cnv_done),
        .bcd   (cnv_bcd)
    );

    // ------------------------------------------------------ output registers
    logic  sat;
    bcd3_t digits;

    // compare at 32 bits so any VAL_W works against the 999 limit
    assign sat = ({{(32 - VAL_W){1'b0}}, cap_val} > 32'(SAT_VAL));

    always_comb begin
        if (sat) begin
            digits = '{d_int: 4'd9, d_f1: 4'd9, d_f2: 4'd9};
        end else begin
            digits = '{d_int: cnv_bcd[11:8], d_f1: cnv_bcd[7:4], d_f2: cnv_bcd[3:0]};
        end
    end

    // Outputs move only in COMMIT, so the display never shows partial results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integer_data <= 4'd0;
            float1_data  <= 4'd0;
            float2_data  <= 4'd0;
            src_id       <= 1'b0;
            overrange    <= 1'b0;
            upd_pulse    <= 1'b0;
        end else begin
            upd_pulse <= 1'b0;
            if (state == ST_COMMIT) begin
                integer_data <= digits.d_int;
                float1_data  <= digits.d_f1;
                float2_data  <= digits.d_f2;
                src_id       <= cap_id;
                overrange    <= sat;
                upd_pulse    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_disp_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_update_ctrl
// Self-checking bench for disp_update_ctrl with REFRESH_CYCLES=32, VAL_W=10.
// A negedge monitor predicts grants from the refresh tick, hold and the
// request lines, pushes the expected display word into exp_q and pops it on
// every upd_pulse. Directed sequences cover conversion, round-robin,
// saturation, hold and reset mid-conversion.
// -----------------------------------------------------------------------------
module tb_disp_update_ctrl;
    localparam int RC = 32;
    localparam int VW = 10;

    // ------------------------------------------------------ clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic hold  = 1'b0;

    logic [3:0] integer_data;
    logic [3:0] float1_data;
    logic [3:0] float2_data;
    logic       src_id;
    logic       overrange;
    logic       upd_pulse;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    disp_update_ctrl_if #(.VAL_W(VW)) sif ();

    disp_update_ctrl #(
        .REFRESH_CYCLES (RC),
        .VAL_W          (VW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src          (sif),
        .hold         (hold),
        .integer_data (integer_data),
        .float1_data  (float1_data),
        .float2_data  (float2_data),
        .src_id       (src_id),
        .overrange    (overrange),
        .upd_pulse    (upd_pulse),
        .dbg_state    (dbg_state)
    );

    // ----------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // display word: {src_id, overrange, int, tenths, hundredths}
    function automatic logic [13:0] exp_disp(input logic gid, input int v);
        if (v > 999) return {gid, 1'b1, 4'd9, 4'd9, 4'd9};
        return {gid, 1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // ------------------------------------------------- reference model
    int m_timer;
    int cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_timer <= 0;
        else        m_timer <= (m_timer == RC - 1) ? 0 : m_timer + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [13:0] exp_q[$];
    int          arb_cyc  = -1;
    int          ack_cyc  = -1;
    int          upd_cyc  = -1;
    int          busy_end = 0;
    logic        ack_gid  = 1'b0;
    logic        m_rr     = 1'b1;
    logic [13:0] shown    = '0;
    int          n_upd    = 0;
    int          n_ack0   = 0;
    int          n_ack1   = 0;

    always @(negedge clk) begin
        logic [13:0] act;
        logic [13:0] e;
        logic        gid;
        logic        e0;
        logic        e1;
        act = {src_id, overrange, integer_data, float1_data, float2_data};
        if (!rst_n) begin
            exp_q.delete();
            arb_cyc  = -1;
            ack_cyc  = -1;
            upd_cyc  = -1;
            busy_end = 0;
            m_rr     = 1'b1;
            shown    = '0;
        end else begin
            e0 = (cyc == ack_cyc) && !ack_gid;
            e1 = (cyc == ack_cyc) &&  ack_gid;
            if (sif.src0_ack) n_ack0++;
            if (sif.src1_ack) n_ack1++;
            if (sif.src0_ack || e0) check_eq("src0_ack", 32'(sif.src0_ack), 32'(e0));
            if (sif.src1_ack || e1) check_eq("src1_ack", 32'(sif.src1_ack), 32'(e1));

            if (upd_pulse) begin
                n_upd++;
                if (exp_q.size() == 0) begin
                    check_eq("upd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("display", 32'(act), 32'(e));
                    check_eq("upd_cycle", 32'(cyc), 32'(upd_cyc));
                end
                shown = act;
            end else begin
                if (cyc == upd_cyc) check_eq("upd_missing", 32'd0, 32'd1);
                if (act != shown) begin
                    check_eq("display_stable", 32'(act), 32'(shown));
                    shown = act;
                end
            end

            if (cyc == arb_cyc) begin
                if (sif.src0_req || sif.src1_req) begin
                    gid      = (sif.src0_req && sif.src1_req) ? ~m_rr : sif.src1_req;
                    m_rr     = gid;
                    exp_q.push_back(exp_disp(gid, gid ? int'(sif.src1_val) : int'(sif.src0_val)));
                    ack_cyc  = cyc + 1;
                    ack_gid  = gid;
                    upd_cyc  = cyc + 2 + VW;
                    busy_end = cyc + 2 + VW;
                end
            end

            if (m_timer == RC - 1 && !hold && cyc >= busy_end) begin
                arb_cyc  = cyc + 1;
                busy_end = cyc + 2;
            end
        end
    end

    // ------------------------------------------------------- driver tasks
    task automatic drive_req(input bit s, input int v);
        if (s) begin
            sif.src1_val = 10'(v);
            sif.src1_req = 1'b1;
        end else begin
            sif.src0_val = 10'(v);
            sif.src0_req = 1'b1;
        end
    endtask

    // wait for the ack of source s, then withdraw its request
    task automatic wait_ack(input bit s);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = s ? sif.src1_ack : sif.src0_ack;
        end
        if (!seen) check_eq(s ? "ack1_timeout" : "ack0_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        if (s) sif.src1_req = 1'b0;
        else   sif.src0_req = 1'b0;
    endtask

    task automatic wait_upd(input int target);
        for (int i = 0; i < 200 && n_upd < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (n_upd < target) check_eq("upd_timeout", 32'(n_upd), 32'(target));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // --------------------------------------------------------- sequences
    initial begin
        int u;
        int a0;
        int a1;
        bit seen;
        sif.src0_req = 1'b0;
        sif.src0_val = '0;
        sif.src1_req = 1'b0;
        sif.src1_val = '0;

        // reset asserted before the first clock edge
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_digits", 32'({integer_data, float1_data, float2_data}), 32'd0);
        check_eq("rst_flags", 32'({src_id, overrange, upd_pulse}), 32'd0);
        check_eq("rst_acks", 32'({sif.src0_ack, sif.src1_ack}), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        idle_cycles(3);
        rst_n = 1'b1;

        // single source, 3.47 V
        u = n_upd;
        drive_req(1'b0, 347);
        wait_ack(1'b0);
        wait_upd(u + 1);
        check_eq("t2_digits", 32'({integer_data, float1_data, float2_data}), 32'h347);
        check_eq("t2_src_id", 32'(src_id), 32'd0);

        // saturation then recovery, both from src1
        u = n_upd;
        drive_req(1'b1, 1023);
        wait_ack(1'b1);
        wait_upd(u + 1);
        check_eq("t4_overrange_set", 32'(overrange), 32'd1);
        drive_req(1'b1, 5);
        wait_ack(1'b1);
        wait_upd(u + 2);
        check_eq("t4_overrange_clr", 32'(overrange), 32'd0);

        // both sources held across three ticks: src0, src1, src0
        u  = n_upd;
        a0 = n_ack0;
        a1 = n_ack1;
        drive_req(1'b0, 100);
        drive_req(1'b1, 205);
        wait_upd(u + 3);
        @(posedge clk);
        #2;
        sif.src0_req = 1'b0;
        sif.src1_req = 1'b0;
        check_eq("t3_ack0_count", 32'(n_ack0 - a0), 32'd2);
        check_eq("t3_ack1_count", 32'(n_ack1 - a1), 32'd1);

        // hold across two ticks drops them
        u  = n_upd;
        a0 = n_ack0;
        hold = 1'b1;
        drive_req(1'b0, 42);
        idle_cycles(70);
        check_eq("t5_hold_no_upd", 32'(n_upd - u), 32'd0);
        check_eq("t5_hold_no_ack", 32'(n_ack0 - a0), 32'd0);
        hold = 1'b0;
        wait_ack(1'b0);
        wait_upd(u + 1);

        // hold raised during CONV does not abort the commit
        u = n_upd;
        drive_req(1'b1, 777);
        wait_ack(1'b1);
        hold = 1'b1;
        wait_upd(u + 1);
        check_eq("t5_hold_in_conv", 32'(n_upd - u), 32'd1);
        hold = 1'b0;

        // reset in the middle of a conversion
        u = n_upd;
        drive_req(1'b0, 500);
        wait_ack(1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_digits", 32'({integer_data, float1_data, float2_data}), 32'd0);
        check_eq("t6_rst_flags", 32'({src_id, overrange, upd_pulse}), 32'd0);
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(20);
        check_eq("t6_no_aborted_upd", 32'(n_upd - u), 32'd0);

        // after reset src0 wins the first contest
        u = n_upd;
        drive_req(1'b0, 111);
        drive_req(1'b1, 222);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = sif.src0_ack | sif.src1_ack;
        end
        check_eq("t6_first_grant_src0", 32'({sif.src1_ack, sif.src0_ack}), 32'd1);
        @(posedge clk);
        #2;
        sif.src0_req = 1'b0;
        sif.src1_req = 1'b0;
        wait_upd(u + 1);
        check_eq("t6_digits", 32'({integer_data, float1_data, float2_data}), 32'h111);

        idle_cycles(40);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
